// File: rtl/rfile_reader.sv
// Register-file read initiator: one-cycle read stage with same-edge write forwarding and
// sub-register field extraction, followed by a 3-entry in-order response FIFO.
module rfile_reader #(
  parameter int XLEN = 64,
  parameter int XWDT = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XWDT-1:0] req_reg,
  input  logic [1:0]      req_size,
  input  logic [2:0]      req_pos,
  input  logic            req_sext,
  output logic [XWDT-1:0] rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            snoop_we,
  input  logic [XWDT-1:0] snoop_reg,
  input  logic [XLEN-1:0] snoop_data,
  input  logic [1:0]      snoop_size,
  input  logic [2:0]      snoop_pos,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [XWDT-1:0] rsp_reg
);

  localparam int OW = $clog2(XLEN);

  typedef struct packed {
    logic [XWDT-1:0] rg;
    logic [XLEN-1:0] data;
  } entry_t;

  // Upper pos bits beyond the field count are dropped, so a position can never run off the register.
  function automatic logic [OW-1:0] field_off(input logic [1:0] size, input logic [2:0] pos);
    case (size)
      2'd0:    field_off = OW'({pos, 3'b000});
      2'd1:    field_off = OW'({pos[1:0], 4'b0000});
      2'd2:    field_off = OW'({pos[0], 5'b00000});
      default: field_off = '0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] field_mask(input logic [1:0] size);
    case (size)
      2'd0:    field_mask = XLEN'(8'hFF);
      2'd1:    field_mask = XLEN'(16'hFFFF);
      2'd2:    field_mask = XLEN'(32'hFFFF_FFFF);
      default: field_mask = '1;
    endcase
  endfunction

  logic            s1_valid;
  logic [XWDT-1:0] s1_reg;
  logic [1:0]      s1_size;
  logic [2:0]      s1_pos;
  logic            s1_sext;
  logic            sn_hit;
  logic [XLEN-1:0] sn_data;
  logic [1:0]      sn_size;
  logic [2:0]      sn_pos;

  entry_t          q0, q1, q2;
  logic [1:0]      count;
  logic [1:0]      wr_idx;
  logic            accept, push, pop;

  logic [XLEN-1:0] wr_mask, merged, shifted, result;
  logic [OW-1:0]   wr_off;

  assign rd_addr   = req_reg;
  assign req_ready = ({1'b0, count} + {2'b00, s1_valid}) < 3'd3;
  assign accept    = req_valid & req_ready;
  assign rsp_valid = (count != 2'd0);
  assign rsp_data  = q0.data;
  assign rsp_reg   = q0.rg;
  assign push      = s1_valid;
  assign pop       = rsp_valid & rsp_ready;
  assign wr_idx    = count - {1'b0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_reg   <= '0;
      s1_size  <= '0;
      s1_pos   <= '0;
      s1_sext  <= 1'b0;
      sn_hit   <= 1'b0;
      sn_data  <= '0;
      sn_size  <= '0;
      sn_pos   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_reg   <= req_reg;
        s1_size  <= req_size;
        s1_pos   <= req_pos;
        s1_sext  <= req_sext;
        // The rfile read started this edge cannot see a write committing on the same edge.
        sn_hit   <= snoop_we && (snoop_reg == req_reg);
        sn_data  <= snoop_data;
        sn_size  <= snoop_size;
        sn_pos   <= snoop_pos;
      end
    end
  end

  always_comb begin
    wr_off  = field_off(sn_size, sn_pos);
    wr_mask = field_mask(sn_size) << wr_off;
    merged  = rd_data;
    if (sn_hit)
      merged = (rd_data & ~wr_mask) | ((sn_data & field_mask(sn_size)) << wr_off);
    shifted = merged >> field_off(s1_size, s1_pos);
    case (s1_size)
      2'd0:    result = {{(XLEN-8){s1_sext & shifted[7]}}, shifted[7:0]};
      2'd1:    result = {{(XLEN-16){s1_sext & shifted[15]}}, shifted[15:0]};
      2'd2:    result = {{(XLEN-32){s1_sext & shifted[31]}}, shifted[31:0]};
      default: result = shifted;
    endcase
  end

  // Shift-register FIFO: entry 0 is always the head, so rsp_* come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0    <= '0;
      q1    <= '0;
      q2    <= '0;
      count <= 2'd0;
    end else begin
      if (push && wr_idx == 2'd0)
        q0 <= '{rg: s1_reg, data: result};
      else if (pop)
        q0 <= q1;
      if (push && wr_idx == 2'd1)
        q1 <= '{rg: s1_reg, data: result};
      else if (pop)
        q1 <= q2;
      if (push && wr_idx == 2'd2)
        q2 <= '{rg: s1_reg, data: result};
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_rfile_reader.sv
// Bench for rfile_reader: behavioural rfile model plus an in-order scoreboard of expected responses.
module tb_rfile_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_reg;
  logic [1:0]  req_size;
  logic [2:0]  req_pos;
  logic        req_sext;
  logic [5:0]  rd_addr;
  logic [63:0] rd_data;
  logic        snoop_we;
  logic [5:0]  snoop_reg;
  logic [63:0] snoop_data;
  logic [1:0]  snoop_size;
  logic [2:0]  snoop_pos;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic [5:0]  rsp_reg;

  typedef struct {
    logic [5:0]  rg;
    logic [63:0] data;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] rf [64];

  localparam logic [63:0] X5 = 64'h8877_6655_4433_2211;

  rfile_reader #(.XLEN(64), .XWDT(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_reg(req_reg),
    .req_size(req_size), .req_pos(req_pos), .req_sext(req_sext),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .snoop_we(snoop_we), .snoop_reg(snoop_reg), .snoop_data(snoop_data),
    .snoop_size(snoop_size), .snoop_pos(snoop_pos),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_reg(rsp_reg)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] m_merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [1:0] sz, input logic [2:0] ps);
    int w, off;
    logic [63:0] r;
    w = 8 << sz;
    off = (int'(ps) % (64 / w)) * w;
    r = old;
    for (int b = 0; b < w; b++) r[off+b] = d[b];
    return r;
  endfunction

  function automatic logic [63:0] m_extract(input logic [63:0] v, input logic [1:0] sz,
                                            input logic [2:0] ps, input logic sx);
    int w, off;
    logic [63:0] r;
    w = 8 << sz;
    off = (int'(ps) % (64 / w)) * w;
    for (int b = 0; b < 64; b++) begin
      if (b < w) r[b] = v[off+b];
      else       r[b] = sx & v[off+w-1];
    end
    return r;
  endfunction

  // Registered-read rfile: the read samples the pre-write contents of the same edge.
  always @(posedge clk) begin
    rd_data <= rf[rd_addr];
    if (snoop_we) rf[snoop_reg] <= m_merge(rf[snoop_reg], snoop_data, snoop_size, snoop_pos);
  end

  task automatic wr(input logic [5:0] rg, input logic [63:0] d, input logic [1:0] sz, input logic [2:0] ps);
    snoop_we = 1'b1; snoop_reg = rg; snoop_data = d; snoop_size = sz; snoop_pos = ps;
    @(negedge clk);
    snoop_we = 1'b0;
  endtask

  task automatic issue(input logic [5:0] rg, input logic [1:0] sz, input logic [2:0] ps,
                       input logic sx, input logic [63:0] ex);
    bit ok = 1'b0;
    req_valid = 1'b1; req_reg = rg; req_size = sz; req_pos = ps; req_sext = sx;
    for (int c = 0; c < 50; c++) begin
      if (req_ready) begin ok = 1'b1; q.push_back('{rg, ex}); break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (!ok) begin n_chk++; n_fail++; $display("FAIL issue_timeout reg%0d req_ready stayed 0", rg); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_reg = '0; req_size = '0; req_pos = '0; req_sext = 1'b0;
    snoop_we = 1'b0; snoop_reg = '0; snoop_data = '0; snoop_size = '0; snoop_pos = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_chk++; if (rsp_data !== 64'h0) begin n_fail++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
    n_chk++; if (rsp_reg !== 6'h0) begin n_fail++; $display("FAIL reset_rsp_reg got %0d exp 0", rsp_reg); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_basic();
    exp_t e;
    wr(6'd5, X5, 2'd3, 3'd0);
    req_valid = 1'b1; req_reg = 6'd5; req_size = 2'd0; req_pos = 3'd3; req_sext = 1'b0;
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready got %b exp 1", req_ready); end
    q.push_back('{6'd5, 64'h44});
    @(negedge clk);
    req_valid = 1'b0;
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_gap rsp_valid got %b exp 0", rsp_valid); end
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency rsp_valid got %b exp 1", rsp_valid); end
    e = q.pop_front();
    n_chk++;
    if (rsp_data !== e.data || rsp_reg !== e.rg) begin
      n_fail++; $display("FAIL basic_data got reg%0d %h exp reg%0d %h", rsp_reg, rsp_data, e.rg, e.data);
    end
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop rsp_valid got %b exp 0", rsp_valid); end
  endtask

  task automatic test_extract();
    fork
      begin
        issue(6'd5, 2'd1, 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_8877);
        issue(6'd5, 2'd1, 3'd2, 1'b1, 64'h0000_0000_0000_6655);
        issue(6'd5, 2'd2, 3'd7, 1'b0, 64'h0000_0000_8877_6655);
        issue(6'd5, 2'd2, 3'd1, 1'b1, 64'hFFFF_FFFF_8877_6655);
        issue(6'd5, 2'd0, 3'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FF88);
        issue(6'd5, 2'd0, 3'd0, 1'b1, 64'h0000_0000_0000_0011);
        issue(6'd5, 2'd3, 3'd5, 1'b1, X5);
        issue(6'd5, 2'd1, 3'd7, 1'b0, 64'h0000_0000_0000_8877);
        issue(6'd5, 2'd2, 3'd0, 1'b1, 64'h0000_0000_4433_2211);
      end
      begin : rx
        exp_t e;
        int got = 0;
        for (int c = 0; c < 200 && got < 9; c++) begin
          if (rsp_valid && rsp_ready) begin
            n_chk++;
            if (q.size() == 0) begin n_fail++; $display("FAIL extract_extra got reg%0d %h exp none", rsp_reg, rsp_data); end
            else begin
              e = q.pop_front(); got++;
              if (rsp_data !== e.data || rsp_reg !== e.rg) begin
                n_fail++; $display("FAIL extract[%0d] got reg%0d %h exp reg%0d %h", got, rsp_reg, rsp_data, e.rg, e.data);
              end
            end
          end
          if (got < 9) @(negedge clk);
        end
        if (got != 9) begin n_chk++; n_fail++; $display("FAIL extract_timeout got %0d exp 9", got); end
      end
    join
    @(negedge clk);
  endtask

  task automatic test_forward();
    fork
      begin
        wr(6'd7, 64'h0, 2'd3, 3'd0);
        snoop_we = 1'b1; snoop_reg = 6'd7; snoop_data = 64'h00AB; snoop_size = 2'd0; snoop_pos = 3'd1;
        issue(6'd7, 2'd3, 3'd0, 1'b0, 64'h0000_0000_0000_AB00);
        snoop_we = 1'b0;
        issue(6'd7, 2'd3, 3'd0, 1'b0, 64'h0000_0000_0000_AB00);
        wr(6'd7, 64'h00CD, 2'd0, 3'd0);
        snoop_we = 1'b1; snoop_reg = 6'd8; snoop_data = 64'hFF; snoop_size = 2'd3; snoop_pos = 3'd0;
        issue(6'd7, 2'd3, 3'd0, 1'b0, 64'h0000_0000_0000_ABCD);
        snoop_we = 1'b0;
        issue(6'd8, 2'd0, 3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(6'd9, 64'h0, 2'd3, 3'd0);
        snoop_we = 1'b1; snoop_reg = 6'd9; snoop_data = 64'h1234_5678_CAFE_BABE; snoop_size = 2'd2; snoop_pos = 3'd7;
        issue(6'd9, 2'd3, 3'd0, 1'b0, 64'hCAFE_BABE_0000_0000);
        snoop_we = 1'b0;
      end
      begin : rx
        exp_t e;
        int got = 0;
        for (int c = 0; c < 200 && got < 5; c++) begin
          if (rsp_valid && rsp_ready) begin
            n_chk++;
            if (q.size() == 0) begin n_fail++; $display("FAIL forward_extra got reg%0d %h exp none", rsp_reg, rsp_data); end
            else begin
              e = q.pop_front(); got++;
              if (rsp_data !== e.data || rsp_reg !== e.rg) begin
                n_fail++; $display("FAIL forward[%0d] got reg%0d %h exp reg%0d %h", got, rsp_reg, rsp_data, e.rg, e.data);
              end
            end
          end
          if (got < 5) @(negedge clk);
        end
        if (got != 5) begin n_chk++; n_fail++; $display("FAIL forward_timeout got %0d exp 5", got); end
      end
    join
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [1:0] sz [6];
    logic [2:0] ps [6];
    logic       sx [6];
    int idx = 0;
    for (int i = 0; i < 6; i++) begin
      sz[i] = 2'($urandom_range(0, 3)); ps[i] = 3'($urandom_range(0, 7)); sx[i] = 1'($urandom_range(0, 1));
    end
    rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_reg = 6'd5; req_size = sz[idx]; req_pos = ps[idx]; req_sext = sx[idx];
      if (req_ready) begin q.push_back('{6'd5, m_extract(rf[5], sz[idx], ps[idx], sx[idx])}); idx++; end
      @(negedge clk);
    end
    n_chk++; if (idx != 3) begin n_fail++; $display("FAIL bp_accepted got %0d exp 3", idx); end
    n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready got %b exp 0", req_ready); end
    rsp_ready = 1'b1;
    fork
      begin
        for (int c = 0; c < 100 && idx < 6; c++) begin
          req_valid = 1'b1; req_reg = 6'd5; req_size = sz[idx]; req_pos = ps[idx]; req_sext = sx[idx];
          if (req_ready) begin q.push_back('{6'd5, m_extract(rf[5], sz[idx], ps[idx], sx[idx])}); idx++; end
          @(negedge clk);
        end
        req_valid = 1'b0;
      end
      begin : rx
        exp_t e;
        int got = 0;
        for (int c = 0; c < 200 && got < 6; c++) begin
          if (rsp_valid && rsp_ready) begin
            n_chk++;
            if (q.size() == 0) begin n_fail++; $display("FAIL bp_extra got reg%0d %h exp none", rsp_reg, rsp_data); end
            else begin
              e = q.pop_front(); got++;
              if (rsp_data !== e.data || rsp_reg !== e.rg) begin
                n_fail++; $display("FAIL bp[%0d] got reg%0d %h exp reg%0d %h", got, rsp_reg, rsp_data, e.rg, e.data);
              end
            end
          end
          if (got < 6) @(negedge clk);
        end
        if (got != 6) begin n_chk++; n_fail++; $display("FAIL bp_timeout got %0d exp 6", got); end
      end
    join
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_dup rsp_valid got %b exp 0", rsp_valid); end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int cycles = 0;
    fork
      begin
        logic [5:0] rg;
        logic [1:0] sz;
        logic [2:0] ps;
        logic       sx;
        rg = 6'd5; sz = 2'd0; ps = 3'd0; sx = 1'b0;
        for (int c = 0; c < 100 && idx < 8; c++) begin
          if (c == cycles) begin
            rg = (idx % 2 == 0) ? 6'd5 : 6'd9;
            sz = 2'($urandom_range(0, 3)); ps = 3'($urandom_range(0, 7)); sx = 1'($urandom_range(0, 1));
          end
          req_valid = 1'b1; req_reg = rg; req_size = sz; req_pos = ps; req_sext = sx;
          if (req_ready) begin q.push_back('{rg, m_extract(rf[rg], sz, ps, sx)}); idx++; cycles++; end
          else cycles = -1000;
          @(negedge clk);
        end
        req_valid = 1'b0;
      end
      begin : rx
        exp_t e;
        int got = 0;
        for (int c = 0; c < 200 && got < 8; c++) begin
          if (rsp_valid && rsp_ready) begin
            n_chk++;
            if (q.size() == 0) begin n_fail++; $display("FAIL b2b_extra got reg%0d %h exp none", rsp_reg, rsp_data); end
            else begin
              e = q.pop_front(); got++;
              if (rsp_data !== e.data || rsp_reg !== e.rg) begin
                n_fail++; $display("FAIL b2b[%0d] got reg%0d %h exp reg%0d %h", got, rsp_reg, rsp_data, e.rg, e.data);
              end
            end
          end
          if (got < 8) @(negedge clk);
        end
        if (got != 8) begin n_chk++; n_fail++; $display("FAIL b2b_timeout got %0d exp 8", got); end
      end
    join
    n_chk++; if (cycles != 8) begin n_fail++; $display("FAIL b2b_throughput stalled, accept run %0d exp 8", cycles); end
    @(negedge clk);
  endtask

  task automatic test_reset_inflight();
    int spurious = 0;
    rsp_ready = 1'b0;
    issue(6'd5, 2'd0, 3'd1, 1'b0, 64'h22);
    issue(6'd5, 2'd0, 3'd2, 1'b0, 64'h33);
    issue(6'd5, 2'd0, 3'd3, 1'b0, 64'h44);
    n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre rsp_valid got %b exp 1", rsp_valid); end
    rst = 1'b1;
    #1;
    n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async rsp_valid got %b exp 0", rsp_valid); end
    n_chk++; if (rsp_data !== 64'h0) begin n_fail++; $display("FAIL rst_async rsp_data got %h exp 0", rsp_data); end
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release req_ready got %b exp 1", req_ready); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) spurious++;
    end
    n_chk++; if (spurious != 0) begin n_fail++; $display("FAIL rst_dropped rsp_valid cycles got %0d exp 0", spurious); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rf[i] = 64'h0;
    rd_data = 64'h0;
    test_reset();
    test_basic();
    test_extract();
    test_forward();
    test_backpressure();
    test_back_to_back();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
